// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the device clock, decodes
// 11-bit frames, and queues good scan codes in a first-word-fall-through FIFO.
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          CLK100MHZ,
  input  logic                          RST,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DATA,
  output logic [7:0]                    DOUT,
  output logic                          DVALID,
  input  logic                          DREADY,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          PARITY_ERR,
  output logic                          FRAME_ERR,
  output logic                          OVERFLOW,
  input  logic                          CLR_ERR,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Valid/ready: DOUT is held stable while DVALID=1; a byte leaves the FIFO
  // on every cycle where DVALID and DREADY are both 1, never otherwise.

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          level, level_d;
  logic [FW-1:0] flt_cnt;
  logic          strobe;

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1  <= PS2_CLK;
      clk_s2  <= clk_s1;
      dat_s1  <= PS2_DATA;
      dat_s2  <= dat_s1;
      level_d <= level;
      // Any sample matching the current level restarts the run of differing samples.
      if (clk_s2 != level) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          level   <= ~level;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign strobe = level_d & ~level;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          push_req, set_par, set_frm, timeout;

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    par_d     = par_q;
    to_d      = '0;
    push_req  = 1'b0;
    set_par   = 1'b0;
    set_frm   = 1'b0;
    timeout   = (state_q != IDLE) && (to_q == TW'(TIMEOUT_CYCLES));
    if (timeout) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (strobe && !dat_s2) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: if (strobe) begin
          sh_d[bit_cnt_q] = dat_s2;
          bit_cnt_d       = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: if (strobe) begin
          par_d   = dat_s2;
          state_d = STOP;
        end
        STOP: if (strobe) begin
          if (!dat_s2)              set_frm  = 1'b1;
          else if (^{sh_q, par_q})  push_req = 1'b1;
          else                      set_par  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d != IDLE && !strobe && !timeout) to_d = to_q + TW'(1);
  end

  assign dbg_state = state_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          full, pop, push, ovf_set;

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop     = DVALID & DREADY;
  assign push    = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  always_ff @(posedge CLK100MHZ) begin
    if (push) mem[wr_ptr] <= sh_q;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign DVALID = (cnt_q != '0);
  assign DOUT   = DVALID ? mem[rd_ptr] : 8'h00;
  assign COUNT  = cnt_q;

  // A set event in the same cycle as CLR_ERR leaves the flag set.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      PARITY_ERR <= set_par | (PARITY_ERR & ~CLR_ERR);
      FRAME_ERR  <= set_frm | (FRAME_ERR & ~CLR_ERR);
      OVERFLOW   <= ovf_set | (OVERFLOW & ~CLR_ERR);
    end
  end

endmodule
